priority_encoder_irq: RTL

//  Parametrised, registered successor to the 4-to-2 one-hot encoder. Captures rising

---
 rtl/priority_encoder_irq_if.sv | 20 ++
 rtl/priority_encoder_irq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/priority_encoder_irq_if.sv
// rtl/priority_encoder_irq_if.sv - valid/ready handshake carrying the encoded request index
interface priority_encoder_irq_if #(
    parameter int IDX_W = 3
);
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/priority_encoder_irq.sv
// rtl/priority_encoder_irq.sv - edge-captured sticky request encoder with handshake output (optional ENC_ROUND_ROBIN_EN)
module priority_encoder_irq #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            en,
    priority_encoder_irq_if.master  grant,
    output logic                    any_pend,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    generate
        if (N < 2 || N > 64 || N > (1 << IDX_W)) begin : g_bad_param
            $error("priority_encoder_irq: N must be 2..64 and fit in IDX_W bits");
        end
    endgenerate

    logic [N-1:0]     req_q;
    logic [N-1:0]     pending;
    logic [N-1:0]     req_edge;
    logic [N-1:0]     ack;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     cand;
    logic [N-1:0]     ovf_hit;
    logic [IDX_W-1:0] win_idx;
    logic             fire;
    logic             load;

    assign fire         = grant.out_valid & grant.out_ready;
    assign load         = ~grant.out_valid | grant.out_ready;
    assign req_edge     = req & ~req_q;
    // A new edge re-arms a line even in the cycle it is being acknowledged
    assign pending_next = (pending & ~ack) | req_edge;
    assign cand         = pending_next & en;
    assign ovf_hit      = req_edge & pending & ~ack;

    // Decode the handshake into a one-hot acknowledge of the held line
    always_comb begin
        ack = '0;
        for (int i = 0; i < N; i++) begin
            ack[i] = fire && (grant.out_idx == IDX_W'(i));
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] last_eff;

    // Rotate from the index being acked this cycle so the next pick already skips it
    assign last_eff = fire ? grant.out_idx : last_idx;

    // Rotating priority: distance 0 is last_eff-1, descending and wrapping; last_eff itself is last
    always_comb begin
        int best;
        int dist;
        best    = N;
        dist    = 0;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                dist = (int'(last_eff) + N - 1 - i) % N;
                if (dist < best) begin
                    best    = dist;
                    win_idx = IDX_W'(i);
                end
            end
        end
    end

    // Remember the most recently acknowledged index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= '0;
        end else if (fire) begin
            last_idx <= grant.out_idx;
        end
    end
`else
    // Fixed priority: the highest set candidate index wins, 0 when none
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Edge capture, pending/overflow bookkeeping and the held output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q           <= '0;
            pending         <= '0;
            any_pend        <= 1'b0;
            ovf             <= 1'b0;
            grant.out_valid <= 1'b0;
            grant.out_idx   <= '0;
        end else begin
            req_q    <= req;
            pending  <= pending_next;
            any_pend <= |cand;
            if (|ovf_hit) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            // A stalled transfer keeps its index even if a higher line arrives
            if (load) begin
                grant.out_valid <= |cand;
                grant.out_idx   <= win_idx;
            end
        end
    end

endmodule
